// File: rtl/data_in_pkg.sv
// Shared widths, FSM states and FIFO word layout for the DMA-to-decompressor
// beat assembler.
package data_in_pkg;
  localparam int BEAT_W      = 512;
  localparam int WORD_W      = 1024;
  localparam int BURST_BEATS = 64;
  localparam int CNT_W       = 26;
  localparam int BEAT_BYTES  = BEAT_W / 8;
  localparam int WORD_BYTES  = WORD_W / 8;

  typedef enum logic [1:0] {IDLE, RECV, DRAIN} state_e;

  typedef struct packed {
    logic [WORD_W-1:0]     data;
    logic [WORD_BYTES-1:0] bv;
  } fifo_word_t;

  // Byte-valid mask of a final beat; tail==0 means the beat is full.
  function automatic logic [BEAT_BYTES-1:0] tail_mask(input logic [5:0] tail);
    if (tail == 6'd0) return '1;
    return (BEAT_BYTES'(1) << tail) - BEAT_BYTES'(1);
  endfunction
endpackage

// File: rtl/wide_fifo.sv
// Show-ahead FIFO over a register array; the head entry is presented whenever
// the FIFO is non-empty and reads as zero when empty.
module wide_fifo #(
  parameter int W     = 1152,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/data_in.sv
// Pairs 512-bit DMA beats into 1024-bit words with per-byte valids, queues them
// for the decompressor and checks last_i against the page length.
module data_in
  import data_in_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [31:0]           compression_length,
  input  logic [BEAT_W-1:0]     data_i,
  input  logic                  valid_i,
  input  logic                  last_i,
  output logic                  ready_o,
  output logic [WORD_W-1:0]     data_o,
  output logic [WORD_BYTES-1:0] byte_valid_o,
  output logic                  valid_o,
  input  logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic                  len_err
);
  state_e                state;
  logic [CNT_W-1:0]      total_beats, beat_cnt;
  logic [5:0]            tail;
  logic [BEAT_W-1:0]     half_q;

  logic                  accept, is_final, exp_last, push, pop;
  logic                  fifo_empty, fifo_full;
  logic [BEAT_BYTES-1:0] bmask;
  logic [BEAT_W-1:0]     beat_m;
  fifo_word_t            push_word, head_word;

  assign busy     = (state != IDLE);
  assign ready_o  = (state == RECV) && !fifo_full;
  assign accept   = valid_i && ready_o;
  assign is_final = (beat_cnt == total_beats - CNT_W'(1));
  assign exp_last = (beat_cnt[5:0] == 6'(BURST_BEATS - 1)) || is_final;
  // Even beats wait in half_q; an odd beat or a lone final even beat pushes.
  assign push     = accept && (beat_cnt[0] || is_final);

  always_comb begin
    bmask  = is_final ? tail_mask(tail) : '1;
    beat_m = '0;
    for (int k = 0; k < BEAT_BYTES; k++)
      beat_m[8*k +: 8] = data_i[8*k +: 8] & {8{bmask[k]}};
  end

  always_comb begin
    push_word = '0;
    if (beat_cnt[0]) begin
      push_word.data = {half_q, beat_m};
      push_word.bv   = {{BEAT_BYTES{1'b1}}, bmask};
    end else begin
      push_word.data = {beat_m, {BEAT_W{1'b0}}};
      push_word.bv   = {bmask, {BEAT_BYTES{1'b0}}};
    end
  end

  assign valid_o      = !fifo_empty;
  assign pop          = valid_o && ready;
  assign data_o       = head_word.data;
  assign byte_valid_o = head_word.bv;

  wide_fifo #(.W($bits(fifo_word_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_word),
    .pop   (pop),
    .rdata (head_word),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      total_beats <= '0;
      tail        <= '0;
      beat_cnt    <= '0;
      half_q      <= '0;
      len_err     <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            total_beats <= compression_length[31:6] + CNT_W'(|compression_length[5:0]);
            tail        <= compression_length[5:0];
            beat_cnt    <= '0;
            len_err     <= 1'b0;
            if (compression_length == 32'd0) done  <= 1'b1;
            else                             state <= RECV;
          end
        end
        RECV: begin
          if (accept) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (!beat_cnt[0]) half_q <= beat_m;
            if (last_i != exp_last) len_err <= 1'b1;
            if (is_final) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/data_in.md
DATA_IN -- requirements
Module: data_in

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of 1024-bit entries in the output FIFO (power of two, at least 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, one-cycle pulse that latches compression_length and begins a page.
REQ-005 SHALL have port compression_length, input, 32, page size in bytes, sampled only when start is accepted.
REQ-006 SHALL have port data_i, input, 512, DMA beat; byte k is data_i[8k+7:8k].
REQ-007 SHALL have port valid_i, input, 1, data_i is valid.
REQ-008 SHALL have port last_i, input, 1, DMA marks the final beat of a 64-beat burst or of the page.
REQ-009 SHALL have port ready_o, output, 1, block accepts a beat.
REQ-010 SHALL have port data_o, output, 1024, assembled word for the decompressor.
REQ-011 SHALL have port byte_valid_o, output, 128, bit k qualifies byte k of data_o.
REQ-012 SHALL have port valid_o, output, 1, data_o is valid.
REQ-013 SHALL have port ready, input, 1, decompressor accepts data_o.
REQ-014 SHALL have port busy, output, 1, page in progress.
REQ-015 SHALL have port done, output, 1, one-cycle pulse when the last word of the page has been consumed.
REQ-016 SHALL have port len_err, output, 1, sticky last_i mismatch flag, cleared by start.

Function
REQ-017 SHALL implement states IDLE, RECV and DRAIN; busy SHALL be 1 in RECV and DRAIN.
REQ-018 In IDLE, start SHALL load total_beats = ceil(compression_length/64) (26 bits) and tail = compression_length[5:0], clear the beat counter and len_err, and move to RECV; if compression_length==0 it SHALL stay in IDLE and pulse done on the next cycle.
REQ-019 start SHALL be ignored while busy.
REQ-020 ready_o SHALL be 1 only in RECV with FIFO count < FIFO_DEPTH; a beat is accepted when valid_i & ready_o.
REQ-021 An even-indexed beat (0,2,...) SHALL be held in a half register as data_o[1023:512]; the next odd beat SHALL form data_o[511:0], and both SHALL be pushed into the FIFO on that acceptance edge.
REQ-022 byte_valid SHALL be all-ones for full beats; on the final beat with tail!=0, only bits [tail-1:0] of that half SHALL be 1, and the data bytes above them SHALL be forced to zero.
REQ-023 If total_beats is odd, the final even beat SHALL be pushed alone on its acceptance edge, with data_o[511:0]=0 and byte_valid_o[63:0]=0.
REQ-024 After the final beat is accepted, the block SHALL move to DRAIN, and ready_o SHALL drop on the next cycle.
REQ-025 valid_o SHALL equal FIFO non-empty; a word pushed at edge N SHALL show valid_o=1 in cycle N+1. Pop on valid_o & ready; data_o SHALL stay stable while valid_o & ~ready.
REQ-026 A simultaneous push and pop SHALL leave the count unchanged; a push when full SHALL NOT occur (REQ-020).
REQ-027 In DRAIN, when the FIFO becomes empty the block SHALL pulse done for 1 cycle and return to IDLE.
REQ-028 When last_i is 1 on an accepted beat, the beat index SHALL satisfy index%64==63 or index==total_beats-1; when that index condition holds, last_i SHALL be 1. On any mismatch len_err SHALL be set; data flow SHALL continue.
REQ-029 Arithmetic: the beat counter is 26 bits and wraps only on reset or start; FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE, empty the FIFO, and clear the half register, beat counter and len_err.
REQ-031 During reset: ready_o=0, valid_o=0, busy=0, done=0, len_err=0, data_o=0, byte_valid_o=0.
REQ-032 Reset mid-page SHALL discard all buffered data with no done pulse; the first start after release SHALL behave as from power-up.

Structure
REQ-033 Package data_in_pkg SHALL hold BEAT_W=512, WORD_W=1024, BURST_BEATS=64, CNT_W=26 and the state enumeration.
REQ-034 The FIFO SHALL be a sub-module wide_fifo (WORD_W+128 bits wide, FIFO_DEPTH deep, registered output, async reset).

Verification
REQ-035 len=256, 4 beats, ready=1 -> two words, byte_valid all-ones, first beat in data_o[1023:512], done once, len_err=0.
REQ-036 len=100 -> beat0 full, beat1 with 36 bytes valid -> one word, byte_valid_o = {64 ones, 28 zeros, 36 ones}, bytes 36..63 of the low half zero.
REQ-037 len=192 (3 beats) -> two words; the second has byte_valid_o[63:0]=0 and data_o[511:0]=0.
REQ-038 len=8192 (128 beats), ready held low -> ready_o drops after 2*FIFO_DEPTH beats; ready released -> all 64 words arrive in order, no loss or duplication.
REQ-039 last_i asserted on beat 10 of a 64-beat burst -> len_err=1 until the next start; output data is unaffected.
REQ-040 rst_n pulsed low mid-page with the FIFO holding 3 words -> outputs at reset values immediately; a new start with len=64 yields one word and done.
